// File: rtl/wb_pkg.sv
// Shared definitions for the MEM/WB writeback stage.
//   wb_state_e : writeback FSM state encoding
//   REG_ZERO   : hardwired-zero register address
package wb_pkg;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_HI   = 1'b1
  } wb_state_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/mem_wb_writeback_seq.sv
// Writeback stage of the 5-stage MULT pipeline. Selects ALU or memory data for the single
// register-file write port. A MULT retires its 64-bit product over two cycles: the low word goes to
// rd in the IDLE cycle and the high word goes to rd+1 in the HI cycle. Upstream stages are stalled
// during the IDLE cycle of a MULT so that MEM/WB holds the MULT through the HI cycle.
//
// Ports:
//   clk, arst_n                         clock, asynchronous active-low reset
//   wb_valid, wb_regwrite, wb_memtoreg  MEM/WB control
//   wb_mult                             MULT: wb_aluout carries a 64-bit product
//   wb_aluout, wb_memreg, wb_rd         MEM/WB data and destination register
//   rf_we, rf_waddr, rf_wdata           register-file write port
//   stall                               hold IF/ID..MEM/WB this cycle
//   busy                                high-word write in progress (HI state)
//   retire_cnt                          retired-instruction count
//
// Build option: define WB_RETIRE_CNT_EN to include the retire counter; otherwise it is tied to 0.
module mem_wb_writeback_seq
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                wb_valid,
  input  logic                wb_regwrite,
  input  logic                wb_memtoreg,
  input  logic                wb_mult,
  input  logic [2*DATA_W-1:0] wb_aluout,
  input  logic [DATA_W-1:0]   wb_memreg,
  input  logic [ADDR_W-1:0]   wb_rd,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                stall,
  output logic                busy,
  output logic [CNT_W-1:0]    retire_cnt
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  wb_state_e         state_q, state_d;
  logic [DATA_W-1:0] hi_word_q, hi_word_d;
  logic [ADDR_W-1:0] hi_addr_q, hi_addr_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= WB_IDLE;
      hi_word_q <= '0;
      hi_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_word_q <= hi_word_d;
      hi_addr_q <= hi_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_word_d = hi_word_q;
    hi_addr_d = hi_addr_q;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    stall     = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (wb_valid && wb_regwrite) begin
          rf_we    = (wb_rd != ZeroAddr);
          rf_waddr = wb_rd;
          if (wb_mult) begin
            rf_wdata  = wb_aluout[DATA_W-1:0];
            stall     = 1'b1;
            hi_word_d = wb_aluout[2*DATA_W-1:DATA_W];
            // Wraps at the top of the register file; a wrapped target of r0 drops the high word.
            hi_addr_d = wb_rd + ADDR_W'(1);
            state_d   = WB_HI;
          end else begin
            rf_wdata = wb_memtoreg ? wb_memreg : wb_aluout[DATA_W-1:0];
          end
        end
      end
      WB_HI: begin
        // MEM/WB still shows the held MULT here; it is deliberately ignored.
        rf_we    = (hi_addr_q != ZeroAddr);
        rf_waddr = hi_addr_q;
        rf_wdata = hi_word_q;
        busy     = 1'b1;
        state_d  = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
    // Outputs go quiet the instant reset asserts, even though MEM/WB may still show a MULT.
    if (!arst_n) begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      stall    = 1'b0;
      busy     = 1'b0;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q;

  // A MULT is counted only on its IDLE cycle; wraps naturally.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      retire_cnt_q <= '0;
    end else if (state_q == WB_IDLE && wb_valid) begin
      retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  assign retire_cnt = retire_cnt_q;
`else
  assign retire_cnt = '0;
`endif

endmodule
